// File: rtl/aadd_pkg.sv
// aadd_pkg: shared approximation-mode constants and FSM state type for the approximate accumulator
package aadd_pkg;
   localparam int MODE_TRUNC = 0;
   localparam int MODE_LOA   = 1;
   typedef enum logic [0:0] {ACCUM = 1'b0, HOLD = 1'b1} state_e;
endpackage

// File: rtl/aadd_stream_acc_core.sv
// aadd_core: combinational ACC_W-bit adder with a DROP-bit approximated lower part
module aadd_core
   import aadd_pkg::*;
#(
   parameter int ACC_W = 48,
   parameter int DROP  = 0,
   parameter int MODE  = MODE_TRUNC
) (
   input  logic [ACC_W-1:0] a,
   input  logic [ACC_W-1:0] b,
   output logic [ACC_W-1:0] s
);
   if (DROP == 0) begin : g_exact
      assign s = a + b;
   end else begin : g_approx
      logic [ACC_W-DROP-1:0] hi;
      logic [DROP-1:0]       lo;
      // the upper part never sees a carry from the low bits
      assign hi = a[ACC_W-1:DROP] + b[ACC_W-1:DROP];
      assign lo = (MODE == MODE_LOA) ? (a[DROP-1:0] | b[DROP-1:0]) : '0;
      assign s  = {hi, lo};
   end
endmodule

// File: rtl/aadd_stream_acc.sv
// aadd_stream_acc: framed streaming accumulator emitting exact and approximate sums per frame
module aadd_stream_acc
   import aadd_pkg::*;
#(
   parameter int W     = 32,
   parameter int ACC_W = 48,
   parameter int DROP  = 0,
   parameter int MODE  = MODE_TRUNC,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_exact,
   output logic [ACC_W-1:0] out_approx,
   output logic [ACC_W-1:0] out_err,
   output logic [CNT_W-1:0] out_cnt,
   output logic             out_ovf
);
   state_e           state_q, state_d;
   logic [ACC_W-1:0] acc_e_q, acc_e_d, acc_a_q, acc_a_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             out_valid_q, out_valid_d;
   logic [ACC_W-1:0] out_exact_q, out_exact_d, out_approx_q, out_approx_d, out_err_q, out_err_d;
   logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
   logic             out_ovf_q, out_ovf_d;
   logic signed [W-1:0] in_s;
   logic [ACC_W-1:0] x, sum_e, sum_a;
   logic [CNT_W-1:0] cnt_inc;
   logic             ovf_inc, accept;
   assign in_s    = in_data;
   assign x       = ACC_W'(in_s);
   assign sum_e   = acc_e_q + x;
   assign cnt_inc = &cnt_q ? cnt_q : cnt_q + 1'b1;
   assign ovf_inc = ovf_q | ((acc_e_q[ACC_W-1] == x[ACC_W-1]) && (sum_e[ACC_W-1] != acc_e_q[ACC_W-1]));
   assign in_ready = state_q == ACCUM;
   assign accept   = in_valid && in_ready;
   aadd_core #(.ACC_W(ACC_W), .DROP(DROP), .MODE(MODE)) u_core (
      .a(acc_a_q),
      .b(x),
      .s(sum_a)
   );
   always_comb begin
      state_d      = state_q;
      acc_e_d      = acc_e_q;
      acc_a_d      = acc_a_q;
      cnt_d        = cnt_q;
      ovf_d        = ovf_q;
      out_valid_d  = out_valid_q;
      out_exact_d  = out_exact_q;
      out_approx_d = out_approx_q;
      out_err_d    = out_err_q;
      out_cnt_d    = out_cnt_q;
      out_ovf_d    = out_ovf_q;
      if (clr) begin
         state_d     = ACCUM;
         acc_e_d     = '0;
         acc_a_d     = '0;
         cnt_d       = '0;
         ovf_d       = 1'b0;
         out_valid_d = 1'b0;
      end else if (accept && in_last) begin
         out_exact_d  = sum_e;
         out_approx_d = sum_a;
         out_err_d    = sum_e - sum_a;
         out_cnt_d    = cnt_inc;
         out_ovf_d    = ovf_inc;
         out_valid_d  = 1'b1;
         acc_e_d      = '0;
         acc_a_d      = '0;
         cnt_d        = '0;
         ovf_d        = 1'b0;
         state_d      = HOLD;
      end else if (accept) begin
         acc_e_d = sum_e;
         acc_a_d = sum_a;
         cnt_d   = cnt_inc;
         ovf_d   = ovf_inc;
      end else if (state_q == HOLD && out_ready) begin
         out_valid_d = 1'b0;
         state_d     = ACCUM;
      end
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ACCUM;
         acc_e_q      <= '0;
         acc_a_q      <= '0;
         cnt_q        <= '0;
         ovf_q        <= 1'b0;
         out_valid_q  <= 1'b0;
         out_exact_q  <= '0;
         out_approx_q <= '0;
         out_err_q    <= '0;
         out_cnt_q    <= '0;
         out_ovf_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         acc_e_q      <= acc_e_d;
         acc_a_q      <= acc_a_d;
         cnt_q        <= cnt_d;
         ovf_q        <= ovf_d;
         out_valid_q  <= out_valid_d;
         out_exact_q  <= out_exact_d;
         out_approx_q <= out_approx_d;
         out_err_q    <= out_err_d;
         out_cnt_q    <= out_cnt_d;
         out_ovf_q    <= out_ovf_d;
      end
   end
   assign out_valid  = out_valid_q;
   assign out_exact  = out_exact_q;
   assign out_approx = out_approx_q;
   assign out_err    = out_err_q;
   assign out_cnt    = out_cnt_q;
   assign out_ovf    = out_ovf_q;
endmodule
